seq_booth_mult: RTL and testbench

Parametrised radix-2 Booth sequential multiplier: the next generation of the team's shift-and-add multiplier. It multiplies two DW-bit operands in either two's-complement or unsigned mode, selected per operation, and produces a 2·DW-bit product. It has a fixed latency that does not depend on the mode. Datapath and control live in one module; it sits behind the same start/ready handshake used by the existing arithmetic blocks.

---
 rtl/seq_booth_mult.sv | 128 ++++++++++++
 tb/tb_seq_booth_mult.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_booth_mult.sv
// Radix-2 Booth sequential multiplier, DW x DW -> 2*DW, signed or unsigned per operation.
// Latency: DW+1 cycles from the start-sampling edge to the one-cycle Ready pulse, either mode.
// Backpressure: none; start is taken only in IDLE or DONE, ignored while busy, clear aborts.
module seq_booth_mult #(
    parameter int DW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              clear,
    input  logic              signed_mode,
    input  logic [DW-1:0]     Multiplicand_INPUT,
    input  logic [DW-1:0]     Multiplier_INPUT,
    output logic              busy,
    output logic              Ready,
    output logic [2*DW-1:0]   Producto
);

    // The step counter must hold DW+1.
    localparam int CW = $clog2(DW + 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state_q;

    // Operands are widened by one bit so unsigned values look like positive
    // signed ones; the Booth recoding then handles both modes identically.
    logic [DW:0]       m_q;        // extended multiplicand
    logic [DW+1:0]     a_q;        // accumulator, one guard bit above M
    logic [DW:0]       q_q;        // extended multiplier, shifted out LSB-first
    logic              qm1_q;      // Booth look-behind bit
    logic [CW-1:0]     cnt_q;      // Booth steps remaining

    logic              busy_q;
    logic              ready_q;
    logic [2*DW-1:0]   prod_q;

    // Next-step datapath values.
    logic [DW+1:0]     m_ext;
    logic [DW+1:0]     a_sum;
    logic [DW+1:0]     a_d;
    logic [DW:0]       q_d;
    logic              qm1_d;

    // Operand extension at capture time.
    logic [DW:0]       mcand_ext;
    logic [DW:0]       mplier_ext;

    assign mcand_ext  = {signed_mode & Multiplicand_INPUT[DW-1], Multiplicand_INPUT};
    assign mplier_ext = {signed_mode & Multiplier_INPUT[DW-1],   Multiplier_INPUT};

    // One Booth step: recode {Q[0], q-1}, add/subtract M, then arithmetic shift {A,Q,q-1}.
    always_comb begin
        m_ext = {m_q[DW], m_q};
        a_sum = a_q;
        unique case ({q_q[0], qm1_q})
            2'b10:   a_sum = a_q - m_ext;
            2'b01:   a_sum = a_q + m_ext;
            default: a_sum = a_q;
        endcase
        {a_d, q_d, qm1_d} = {a_sum[DW+1], a_sum, q_q};
    end

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            m_q     <= '0;
            a_q     <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            prod_q  <= '0;
        end else if (clear) begin
            // Abort wins over start; the last product stays visible.
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    ready_q <= 1'b0;
                    if (start) begin
                        m_q     <= mcand_ext;
                        a_q     <= '0;
                        q_q     <= mplier_ext;
                        qm1_q   <= 1'b0;
                        cnt_q   <= CW'(DW + 1);
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    a_q   <= a_d;
                    q_q   <= q_d;
                    qm1_q <= qm1_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        // Last step: the low 2*DW bits of {A,Q} are exact in both modes.
                        prod_q  <= {a_d[DW-2:0], q_d};
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign Ready    = ready_q;
    assign Producto = prod_q;

endmodule

// File: tb/tb_seq_booth_mult.sv
// Bench for seq_booth_mult at DW = 4, 8 and 16.
// Each instance has a cycle-level reference model; outputs are compared every cycle.
// Directed vectors carry hand-computed products and latencies.
module tb_seq_booth_mult;

    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start_s [NI];
    logic        clear_s [NI];
    logic        sm_s    [NI];
    logic [15:0] a_s     [NI];
    logic [15:0] b_s     [NI];
    logic        busy_w  [NI];
    logic        rdy_w   [NI];
    logic [31:0] prod_w  [NI];

    int total = 0;
    int bad   = 0;

    function automatic int width_of(int i);
        return (i == 0) ? 4 : ((i == 1) ? 8 : 16);
    endfunction

    // Reference product straight from integer arithmetic.
    function automatic logic [31:0] ref_prod(int w, logic sm, logic [15:0] a, logic [15:0] b);
        longint sa, sb, p, mask;
        mask = (64'sd1 <<< w) - 1;
        sa = longint'(a) & mask;
        sb = longint'(b) & mask;
        if (sm && sa[w-1]) sa = sa - (64'sd1 <<< w);
        if (sm && sb[w-1]) sb = sb - (64'sd1 <<< w);
        p = sa * sb;
        return 32'(p & ((64'sd1 <<< (2 * w)) - 1));
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int W = (g == 0) ? 4 : ((g == 1) ? 8 : 16);
        logic [2*W-1:0] p;
        logic           bz;
        logic           rd;

        seq_booth_mult #(.DW(W)) dut (
            .clk                (clk),
            .rst                (rst),
            .start              (start_s[g]),
            .clear              (clear_s[g]),
            .signed_mode        (sm_s[g]),
            .Multiplicand_INPUT (a_s[g][W-1:0]),
            .Multiplier_INPUT   (b_s[g][W-1:0]),
            .busy               (bz),
            .Ready              (rd),
            .Producto           (p)
        );

        assign busy_w[g] = bz;
        assign rdy_w[g]  = rd;
        assign prod_w[g] = 32'(p);

        // Model: cycles left until the result, the Ready pulse and the held product.
        int          m_cnt  = 0;
        logic        m_rdy  = 1'b0;
        logic [31:0] m_prod = '0;
        logic [31:0] m_pend = '0;

        always @(posedge clk or negedge rst) begin
            if (!rst) begin
                m_cnt  = 0;
                m_rdy  = 1'b0;
                m_prod = '0;
            end else if (clear_s[g]) begin
                m_cnt = 0;
                m_rdy = 1'b0;
            end else if (m_cnt > 0) begin
                m_cnt = m_cnt - 1;
                m_rdy = (m_cnt == 0);
                if (m_cnt == 0) m_prod = m_pend;
            end else begin
                m_rdy = 1'b0;
                if (start_s[g]) begin
                    m_cnt  = W + 1;
                    m_pend = ref_prod(W, sm_s[g], a_s[g], b_s[g]);
                end
            end
        end

        always @(negedge clk) begin
            check($sformatf("busy_dw%0d", W),  32'(bz), 32'(m_cnt > 0));
            check($sformatf("ready_dw%0d", W), 32'(rd), 32'(m_rdy));
            check($sformatf("prod_dw%0d", W),  32'(p),  m_prod);
        end
    end

    task automatic wait_ready(int i, output int n);
        n = 0;
        while (!rdy_w[i] && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run_op(int i, logic sm, logic [15:0] a, logic [15:0] b,
                          output logic [31:0] prod, output int lat);
        @(posedge clk); #1;
        start_s[i] = 1'b1;
        sm_s[i]    = sm;
        a_s[i]     = a;
        b_s[i]     = b;
        @(posedge clk); #1;
        start_s[i] = 1'b0;
        a_s[i]     = 16'($urandom);
        b_s[i]     = 16'($urandom);
        sm_s[i]    = 1'($urandom);
        wait_ready(i, lat);
        prod = prod_w[i];
    endtask

    initial begin
        logic [31:0] p;
        int          l;
        int          n;
        logic        saw;
        logic        rs;
        logic [15:0] ra, rb;

        rst = 1'b0;
        for (int i = 0; i < NI; i++) begin
            start_s[i] = 1'b0;
            clear_s[i] = 1'b0;
            sm_s[i]    = 1'b0;
            a_s[i]     = '0;
            b_s[i]     = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < NI; i++) begin
            check("reset_busy",  32'(busy_w[i]), 32'h0);
            check("reset_ready", 32'(rdy_w[i]),  32'h0);
            check("reset_prod",  prod_w[i],      32'h0);
        end

        // DW=8 signed
        run_op(1, 1'b1, 16'h0080, 16'h0080, p, l);
        check("s8_m128_m128", p, 32'h4000);
        check("s8_latency", 32'(l), 32'd9);
        @(posedge clk); #1;
        check("ready_width", 32'(rdy_w[1]), 32'h0);
        run_op(1, 1'b1, 16'h007F, 16'h0080, p, l);
        check("s8_127_m128", p, 32'hC080);
        run_op(1, 1'b1, 16'h00FF, 16'h0001, p, l);
        check("s8_m1_1", p, 32'hFFFF);

        // DW=8 unsigned
        run_op(1, 1'b0, 16'h00FF, 16'h00FF, p, l);
        check("u8_ff_ff", p, 32'hFE01);
        check("u8_latency", 32'(l), 32'd9);
        run_op(1, 1'b0, 16'h0080, 16'h0002, p, l);
        check("u8_80_02", p, 32'h0100);

        // start pulsed during RUN is ignored
        @(posedge clk); #1;
        start_s[1] = 1'b1; sm_s[1] = 1'b0; a_s[1] = 16'd3; b_s[1] = 16'd5;
        @(posedge clk); #1;
        start_s[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        start_s[1] = 1'b1; a_s[1] = 16'd7; b_s[1] = 16'd9;
        @(posedge clk); #1;
        start_s[1] = 1'b0;
        wait_ready(1, n);
        check("ignore_start_prod", prod_w[1], 32'd15);
        check("ignore_start_lat", 32'(4 + n), 32'd9);

        // start held through DONE gives back-to-back results DW+2 apart
        @(posedge clk); #1;
        start_s[1] = 1'b1; sm_s[1] = 1'b1; a_s[1] = 16'h00FD; b_s[1] = 16'h0007;
        @(posedge clk); #1;
        sm_s[1] = 1'b0; a_s[1] = 16'h000C; b_s[1] = 16'h000B;
        wait_ready(1, n);
        check("b2b_first_lat", 32'(n), 32'd9);
        check("b2b_first_prod", prod_w[1], 32'hFFEB);
        @(posedge clk); #1;
        start_s[1] = 1'b0;
        check("b2b_ready_width", 32'(rdy_w[1]), 32'h0);
        wait_ready(1, n);
        check("b2b_period", 32'(n + 1), 32'd10);
        check("b2b_second_prod", prod_w[1], 32'h0084);

        // clear sampled on the fourth Booth step
        @(posedge clk); #1;
        start_s[1] = 1'b1; sm_s[1] = 1'b0; a_s[1] = 16'h0010; b_s[1] = 16'h0010;
        @(posedge clk); #1;
        start_s[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1 clear_s[1] = 1'b1;
        @(posedge clk); #1;
        clear_s[1] = 1'b0;
        check("clear_busy", 32'(busy_w[1]), 32'h0);
        saw = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (rdy_w[1]) saw = 1'b1;
        end
        check("clear_no_ready", 32'(saw), 32'h0);
        check("clear_prod_kept", prod_w[1], 32'h0084);

        // asynchronous reset in the middle of an operation
        @(posedge clk); #1;
        start_s[1] = 1'b1; sm_s[1] = 1'b1; a_s[1] = 16'h0033; b_s[1] = 16'h0044;
        @(posedge clk); #1;
        start_s[1] = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_busy",  32'(busy_w[1]), 32'h0);
        check("rst_ready", 32'(rdy_w[1]),  32'h0);
        check("rst_prod",  prod_w[1],      32'h0);
        #2 rst = 1'b1;
        run_op(1, 1'b0, 16'h0005, 16'h0006, p, l);
        check("after_rst_prod", p, 32'h001E);
        check("after_rst_lat", 32'(l), 32'd9);

        // DW=16
        run_op(2, 1'b1, 16'h8000, 16'h8000, p, l);
        check("s16_min_sq", p, 32'h40000000);
        check("s16_latency", 32'(l), 32'd17);
        run_op(2, 1'b0, 16'hFFFF, 16'hFFFF, p, l);
        check("u16_ffff_sq", p, 32'hFFFE0001);
        check("u16_latency", 32'(l), 32'd17);

        // DW=4
        run_op(0, 1'b1, 16'h0008, 16'h0008, p, l);
        check("s4_m8_sq", p, 32'h0040);
        check("s4_latency", 32'(l), 32'd5);
        run_op(0, 1'b0, 16'h000F, 16'h000F, p, l);
        check("u4_f_sq", p, 32'h00E1);

        // random regression across widths and modes
        for (int i = 0; i < NI; i++) begin
            for (int k = 0; k < 15; k++) begin
                rs = 1'($urandom);
                ra = 16'($urandom);
                rb = 16'($urandom);
                run_op(i, rs, ra, rb, p, l);
                check($sformatf("rand_prod_dw%0d", width_of(i)), p, ref_prod(width_of(i), rs, ra, rb));
                check($sformatf("rand_lat_dw%0d", width_of(i)), 32'(l), 32'(width_of(i) + 1));
            end
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
